// File: rtl/maze_pkg.sv
// Shared encodings for the maze game controller: FSM states, difficulty codes
// and move-pulse bit positions.
package maze_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_MENU     = 3'd0;
  localparam state_t ST_SHOW_MAP = 3'd1;
  localparam state_t ST_PLAYING  = 3'd2;
  localparam state_t ST_FETCH    = 3'd3;
  localparam state_t ST_CHECK    = 3'd4;
  localparam state_t ST_LOST     = 3'd5;
  localparam state_t ST_WON      = 3'd6;

  localparam logic [1:0] DIFF_EASY = 2'd0;
  localparam logic [1:0] DIFF_MED  = 2'd1;
  localparam logic [1:0] DIFF_HARD = 2'd2;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

endpackage

// File: rtl/maze_move_calc.sv
// Combinational move candidate: one-hot check on the move pulses, +/-1 step on
// the chosen axis, and bounds check done in signed POS_W+1 so 0-1 never wraps.
module maze_move_calc
  import maze_pkg::*;
#(
  parameter int MAP_W = 30,
  parameter int MAP_H = 21,
  parameter int POS_W = 8
) (
  input  logic [3:0]       move_i,
  input  logic [POS_W-1:0] pos_x_i,
  input  logic [POS_W-1:0] pos_y_i,
  output logic [POS_W-1:0] cand_x_o,
  output logic [POS_W-1:0] cand_y_o,
  output logic             valid_o
);

  localparam logic signed [POS_W:0] ZERO = '0;
  localparam logic signed [POS_W:0] ONE  = (POS_W+1)'(1);
  localparam logic signed [POS_W:0] XMAX = (POS_W+1)'(MAP_W - 1);
  localparam logic signed [POS_W:0] YMAX = (POS_W+1)'(MAP_H - 1);

  logic signed [POS_W:0] px, py, cx, cy;
  logic                  one_hot, in_bounds;

  always_comb begin
    px = $signed({1'b0, pos_x_i});
    py = $signed({1'b0, pos_y_i});
    cx = px;
    cy = py;
    if (move_i[DIR_UP])    cy = py - ONE;
    if (move_i[DIR_DOWN])  cy = py + ONE;
    if (move_i[DIR_LEFT])  cx = px - ONE;
    if (move_i[DIR_RIGHT]) cx = px + ONE;
    one_hot   = (move_i != 4'b0000) && ((move_i & (move_i - 4'd1)) == 4'b0000);
    in_bounds = (cx >= ZERO) && (cx <= XMAX) && (cy >= ZERO) && (cy <= YMAX);
  end

  assign cand_x_o = cx[POS_W-1:0];
  assign cand_y_o = cy[POS_W-1:0];
  assign valid_o  = one_hot && in_bounds;

endmodule

// File: rtl/maze_game_ctrl.sv
// Maze game FSM: difficulty-timed map reveal, bounds-checked moves, wall check
// against a 1-cycle ROM (PLAYING -> FETCH -> CHECK) and goal detection.
module maze_game_ctrl
  import maze_pkg::*;
#(
  parameter int MAP_W     = 30,
  parameter int MAP_H     = 21,
  parameter int POS_W     = 8,
  parameter int START_X   = 0,
  parameter int START_Y   = 20,
  parameter int GOAL_X    = 29,
  parameter int GOAL_Y    = 0,
  parameter int SHOW_EASY = 100000000,
  parameter int SHOW_MED  = 50000000,
  parameter int SHOW_HARD = 25000000,
  parameter int CNT_W     = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [1:0]                 diff_sel,
  input  logic [3:0]                 move,
  output logic [$clog2(MAP_H)-1:0]   map_addr,
  input  logic [MAP_W-1:0]           map_data,
  output logic [POS_W-1:0]           player_x,
  output logic [POS_W-1:0]           player_y,
  output logic [2:0]                 state,
  output logic                       map_visible,
  output logic                       lost,
  output logic                       won
);

  localparam int AW = $clog2(MAP_H);
  localparam int XW = $clog2(MAP_W);

  state_t            state_q, state_d;
  logic [POS_W-1:0]  px_q, px_d, py_q, py_d;
  logic [POS_W-1:0]  cx_q, cx_d, cy_q, cy_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, show_lim;
  logic [1:0]        diff_q, diff_d;

  logic [POS_W-1:0]  cand_x, cand_y;
  logic              mv_valid, wall, at_goal;

  maze_move_calc #(.MAP_W(MAP_W), .MAP_H(MAP_H), .POS_W(POS_W)) u_move_calc (
    .move_i  (move),
    .pos_x_i (px_q),
    .pos_y_i (py_q),
    .cand_x_o(cand_x),
    .cand_y_o(cand_y),
    .valid_o (mv_valid)
  );

  always_comb begin
    case (diff_q)
      DIFF_EASY: show_lim = CNT_W'(SHOW_EASY - 1);
      DIFF_MED:  show_lim = CNT_W'(SHOW_MED - 1);
      default:   show_lim = CNT_W'(SHOW_HARD - 1);
    endcase
  end

  // map_data reflects the row addressed two edges earlier, i.e. cy_q, by CHECK
  assign wall    = map_data[cx_q[XW-1:0]];
  assign at_goal = (cx_q == POS_W'(GOAL_X)) && (cy_q == POS_W'(GOAL_Y));

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    case (state_q)
      ST_MENU: if (start) begin
        diff_d  = diff_sel;
        px_d    = POS_W'(START_X);
        py_d    = POS_W'(START_Y);
        cnt_d   = '0;
        state_d = ST_SHOW_MAP;
      end
      ST_SHOW_MAP: begin
        if (cnt_q == show_lim) begin
          cnt_d   = '0;
          state_d = ST_PLAYING;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PLAYING: if (mv_valid) begin
        cx_d    = cand_x;
        cy_d    = cand_y;
        addr_d  = cand_y[AW-1:0];
        state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_CHECK;
      ST_CHECK: begin
        px_d = cx_q;
        py_d = cy_q;
        if (wall)         state_d = ST_LOST;
        else if (at_goal) state_d = ST_WON;
        else              state_d = ST_PLAYING;
      end
      ST_LOST, ST_WON: if (start) state_d = ST_MENU;
      default: state_d = ST_MENU;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_MENU;
      px_q    <= POS_W'(START_X);
      py_q    <= POS_W'(START_Y);
      cx_q    <= POS_W'(START_X);
      cy_q    <= POS_W'(START_Y);
      addr_q  <= AW'(START_Y);
      cnt_q   <= '0;
      diff_q  <= DIFF_EASY;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      py_q    <= py_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
    end
  end

  assign state       = state_q;
  assign player_x    = px_q;
  assign player_y    = py_q;
  assign map_addr    = addr_q;
  assign lost        = (state_q == ST_LOST);
  assign won         = (state_q == ST_WON);
  assign map_visible = (state_q == ST_SHOW_MAP) || lost || won;

endmodule

// File: tb/tb_maze_game_ctrl.sv
// Directed bench for maze_game_ctrl with a behavioural 1-cycle map ROM.
module tb_maze_game_ctrl;
  import maze_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  diff_sel;
  logic [3:0]  move;
  logic [4:0]  map_addr;
  logic [29:0] map_data;
  logic [7:0]  player_x, player_y;
  logic [2:0]  state;
  logic        map_visible, lost, won;

  logic [29:0] rom [0:20];
  int tests = 0;
  int fails = 0;

  maze_game_ctrl #(
    .SHOW_EASY(12), .SHOW_MED(8), .SHOW_HARD(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .diff_sel(diff_sel),
    .move(move), .map_addr(map_addr), .map_data(map_data),
    .player_x(player_x), .player_y(player_y), .state(state),
    .map_visible(map_visible), .lost(lost), .won(won)
  );

  always #5 clk = ~clk;

  always @(posedge clk) map_data <= rom[map_addr];

  typedef struct {
    logic [3:0] mv;
    logic [7:0] ex;
    logic [7:0] ey;
    logic [2:0] es;
    logic [4:0] ea;
  } vec_t;
  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_move(input logic [3:0] m);
    move = m;
    tick();
    move = 4'b0000;
  endtask

  task automatic step(input logic [3:0] m);
    pulse_move(m);
    repeat (3) tick();
  endtask

  task automatic pulse_start(input logic [1:0] d);
    diff_sel = d;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Counts sampled cycles spent in SHOW_MAP, bounded so a stuck FSM cannot hang.
  task automatic count_show(output int n);
    n = 0;
    while (state == ST_SHOW_MAP && n < 50) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    for (int r = 0; r < 21; r++) rom[r] = '0;
    reset_n  = 1'b0;
    start    = 1'b0;
    diff_sel = 2'd0;
    move     = 4'b0000;

    vecs[0] = '{4'b0010, 8'd0, 8'd19, ST_PLAYING, 5'd19};
    vecs[1] = '{4'b1010, 8'd0, 8'd19, ST_PLAYING, 5'd19};
    vecs[2] = '{4'b0000, 8'd0, 8'd19, ST_PLAYING, 5'd19};
    vecs[3] = '{4'b0100, 8'd0, 8'd20, ST_PLAYING, 5'd20};
    vecs[4] = '{4'b0100, 8'd0, 8'd20, ST_PLAYING, 5'd20};
    vecs[5] = '{4'b0001, 8'd1, 8'd20, ST_PLAYING, 5'd20};
    vecs[6] = '{4'b0010, 8'd0, 8'd20, ST_PLAYING, 5'd20};
    vecs[7] = '{4'b1000, 8'd0, 8'd19, ST_PLAYING, 5'd19};
    vecs[8] = '{4'b0100, 8'd0, 8'd20, ST_PLAYING, 5'd20};

    #12;
    chk("rst_state", state, ST_MENU);
    chk("rst_x", player_x, 0);
    chk("rst_y", player_y, 20);
    chk("rst_addr", map_addr, 20);
    chk("rst_flags", {map_visible, lost, won}, 3'b000);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Medium reveal; move and start held during SHOW_MAP must be ignored.
    pulse_start(2'd1);
    chk("show_vis", map_visible, 1);
    move  = 4'b1000;
    start = 1'b1;
    count_show(n);
    move  = 4'b0000;
    start = 1'b0;
    chk("show_med_dwell", n, 8);
    chk("play_state", state, ST_PLAYING);
    chk("play_vis", map_visible, 0);
    chk("play_x", player_x, 0);
    chk("play_y", player_y, 20);

    // Up from (0,20): 3-edge move-to-commit latency.
    pulse_move(4'b1000);
    chk("lat_e1_state", state, ST_FETCH);
    chk("lat_e1_addr", map_addr, 19);
    chk("lat_e1_y", player_y, 20);
    tick();
    chk("lat_e2_state", state, ST_CHECK);
    chk("lat_e2_y", player_y, 20);
    tick();
    chk("lat_e3_state", state, ST_PLAYING);
    chk("lat_e3_y", player_y, 19);

    for (int i = 0; i < 9; i++) begin
      step(vecs[i].mv);
      chk($sformatf("vec%0d_x", i), player_x, vecs[i].ex);
      chk($sformatf("vec%0d_y", i), player_y, vecs[i].ey);
      chk($sformatf("vec%0d_state", i), state, vecs[i].es);
      chk($sformatf("vec%0d_addr", i), map_addr, vecs[i].ea);
    end

    // Second up pulse lands in FETCH and must be dropped.
    pulse_move(4'b1000);
    pulse_move(4'b1000);
    repeat (3) tick();
    chk("drop_y", player_y, 19);
    chk("drop_state", state, ST_PLAYING);
    step(4'b0100);

    // Wall at row 20 column 1.
    rom[20] = 30'b10;
    step(4'b0001);
    chk("wall_x", player_x, 1);
    chk("wall_y", player_y, 20);
    chk("wall_state", state, ST_LOST);
    chk("wall_flags", {map_visible, lost, won}, 3'b110);
    pulse_start(2'd0);
    chk("lost_menu", state, ST_MENU);
    chk("lost_clear", {map_visible, lost, won}, 3'b000);
    chk("lost_frozen_x", player_x, 1);
    rom[20] = '0;

    // Hard game: walk to the goal with no walls.
    pulse_start(2'd2);
    chk("reload_x", player_x, 0);
    count_show(n);
    chk("show_hard_dwell", n, 4);
    for (int i = 0; i < 29; i++) step(4'b0001);
    chk("path_x", player_x, 29);
    chk("path_state", state, ST_PLAYING);
    for (int i = 0; i < 19; i++) step(4'b1000);
    chk("near_goal_y", player_y, 1);
    chk("near_goal_state", state, ST_PLAYING);
    step(4'b1000);
    chk("goal_y", player_y, 0);
    chk("goal_state", state, ST_WON);
    chk("goal_flags", {map_visible, lost, won}, 3'b101);
    step(4'b0100);
    chk("won_frozen_y", player_y, 0);
    pulse_start(2'd0);
    chk("won_menu", state, ST_MENU);

    // Easy game, then asynchronous reset while in FETCH.
    pulse_start(2'd0);
    count_show(n);
    chk("show_easy_dwell", n, 12);
    pulse_move(4'b1000);
    chk("pre_rst_state", state, ST_FETCH);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_state", state, ST_MENU);
    chk("arst_pos", {player_x, player_y}, {8'd0, 8'd20});
    chk("arst_addr", map_addr, 20);
    chk("arst_flags", {map_visible, lost, won}, 3'b000);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_state", state, ST_MENU);
    chk("post_rst_y", player_y, 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
